fetch_pair_buffer: RTL

Dual-issue instruction buffer between instruction fetch and the decode/immediate-generation stage. Accepts up to two 32-bit instructions per cycle from fetch and presents the two oldest buffered instructions as slot A (older) and slot B (younger), with PCs and valid bits. Decode consumes 0, 1 or 2 per cycle, so a pair split by a hazard is re-presented without refetch. A flush empties the buffer on redirects.

---
 rtl/fetch_pair_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_pair_buffer.sv
// ============================================================================
// fetch_pair_buffer
//   Dual-issue instruction buffer between fetch and decode. Accepts up to two
//   instructions per cycle and presents the two oldest as slots A and B.
//   Optional same-cycle bypass when empty: define FETCH_BUF_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_pair_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     fetch_valid,
  input  logic                     fetch_valid1,
  input  logic [31:0]              fetch_instr0,
  input  logic [31:0]              fetch_instr1,
  input  logic [XLEN-1:0]          fetch_pc0,
  input  logic [XLEN-1:0]          fetch_pc1,
  output logic                     fetch_ready,
  output logic [31:0]              instrA,
  output logic [31:0]              instrB,
  output logic [XLEN-1:0]          pcA,
  output logic [XLEN-1:0]          pcB,
  output logic                     validA,
  output logic                     validB,
  input  logic [1:0]               deq_cnt,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [31:0]     instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic [c_AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [c_AW-1:0] w_head1, w_wr1_addr;
  logic [c_CW-1:0] count_q, count_d;
  logic            w_push_ok, w_bypass, w_occ_a, w_occ_b, w_wr0_en, w_wr1_en;
  logic [1:0]      w_push_n, w_deq_req, w_avail, w_pop, w_skip;

  assign count       = count_q;
  assign fetch_ready = (c_CW'(DEPTH) - count_q) >= c_CW'(2);
  assign w_occ_a     = (count_q != '0);
  assign w_occ_b     = (count_q >= c_CW'(2));
  assign w_head1     = head_q + c_AW'(1);

  assign w_push_ok = fetch_valid && fetch_ready && !flush;
  assign w_push_n  = w_push_ok ? (fetch_valid1 ? 2'd2 : 2'd1) : 2'd0;
  assign w_deq_req = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;

`ifdef FETCH_BUF_BYPASS_EN
  assign w_bypass = w_push_ok && (count_q == '0);
`else
  assign w_bypass = 1'b0;
`endif

  // Instructions consumed straight from the fetch packet are never written.
  assign w_avail    = w_bypass ? w_push_n : ({1'b0, w_occ_a} + {1'b0, w_occ_b});
  assign w_pop      = (w_deq_req < w_avail) ? w_deq_req : w_avail;
  assign w_skip     = w_bypass ? w_pop : 2'd0;
  assign w_wr0_en   = w_push_ok && (w_skip == 2'd0);
  assign w_wr1_en   = w_push_ok && fetch_valid1 && (w_skip != 2'd2);
  assign w_wr1_addr = (w_skip == 2'd0) ? (tail_q + c_AW'(1)) : tail_q;

  always_comb begin
    head_d  = head_q + c_AW'(w_pop - w_skip);
    tail_d  = tail_q + c_AW'(w_push_n - w_skip);
    count_d = count_q + c_CW'(w_push_n) - c_CW'(w_pop);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr0_en) begin
      instr_mem_q[tail_q] <= fetch_instr0;
      pc_mem_q[tail_q]    <= fetch_pc0;
    end
    if (w_wr1_en) begin
      instr_mem_q[w_wr1_addr] <= fetch_instr1;
      pc_mem_q[w_wr1_addr]    <= fetch_pc1;
    end
  end

  // Empty slots read as zero so the immediate generator downstream yields 0.
  always_comb begin
    validA = w_occ_a;
    validB = w_occ_b;
    instrA = w_occ_a ? instr_mem_q[head_q]  : 32'h0;
    pcA    = w_occ_a ? pc_mem_q[head_q]     : '0;
    instrB = w_occ_b ? instr_mem_q[w_head1] : 32'h0;
    pcB    = w_occ_b ? pc_mem_q[w_head1]    : '0;
`ifdef FETCH_BUF_BYPASS_EN
    if (w_bypass) begin
      validA = 1'b1;
      validB = fetch_valid1;
      instrA = fetch_instr0;
      pcA    = fetch_pc0;
      instrB = fetch_valid1 ? fetch_instr1 : 32'h0;
      pcB    = fetch_valid1 ? fetch_pc1 : '0;
    end
`endif
  end

endmodule

`default_nettype wire
